// File: rtl/gpio_pad_pkg.sv
// Shared definitions for the GPIO pad controller: register addresses,
// per-bit reset values and the write-one-to-clear status update.
package gpio_pad_pkg;

  localparam logic [3:0] ADDR_DOUT    = 4'd0;
  localparam logic [3:0] ADDR_OE      = 4'd1;
  localparam logic [3:0] ADDR_OD      = 4'd2;
  localparam logic [3:0] ADDR_IE      = 4'd3;
  localparam logic [3:0] ADDR_PU      = 4'd4;
  localparam logic [3:0] ADDR_PD      = 4'd5;
  localparam logic [3:0] ADDR_DS0     = 4'd6;
  localparam logic [3:0] ADDR_DS1     = 4'd7;
  localparam logic [3:0] ADDR_CS      = 4'd8;
  localparam logic [3:0] ADDR_DIN     = 4'd9;
  localparam logic [3:0] ADDR_RISE_EN = 4'd10;
  localparam logic [3:0] ADDR_FALL_EN = 4'd11;
  localparam logic [3:0] ADDR_STAT    = 4'd12;

  // Reset value of a single bit; every register bit of a given register
  // resets to the same value, so the top replicates these NPIN times.
  localparam logic RST_DOUT    = 1'b0;
  localparam logic RST_OE      = 1'b0;
  localparam logic RST_OD      = 1'b0;
  localparam logic RST_IE      = 1'b1;
  localparam logic RST_PU      = 1'b0;
  localparam logic RST_PD      = 1'b0;
  localparam logic RST_DS0     = 1'b0;
  localparam logic RST_DS1     = 1'b0;
  localparam logic RST_CS      = 1'b0;
  localparam logic RST_RISE_EN = 1'b0;
  localparam logic RST_FALL_EN = 1'b0;
  localparam logic RST_STAT    = 1'b0;

  // Widest status register the helper supports; callers zero-extend into it.
  localparam int W1C_W = 32;

  // Clear the bits written as one, then OR in new events so a set that
  // lands in the same cycle as its clear is never lost.
  function automatic logic [W1C_W-1:0] w1c_update(
    input logic [W1C_W-1:0] cur,
    input logic [W1C_W-1:0] clr,
    input logic [W1C_W-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: two-flop synchroniser, debounce filter that
// only accepts a new level after DEB_CYC consecutive samples, and raw
// rise/fall event detection on the debounced level.
module gpio_in_filter
  import gpio_pad_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_c,
  output logic stable,
  output logic rise_evt,
  output logic fall_evt
);

  logic s1;
  logic s2;
  logic prev;

  // Bring the asynchronous pad level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad_c;
      s2 <= s1;
    end
  end

  if (DEB_CYC == 0) begin : g_bypass
    // No debounce: the debounced level simply follows the synchroniser.
    always_ff @(posedge clk) begin
      if (rst) stable <= 1'b0;
      else     stable <= s2;
    end
  end else begin : g_deb
    localparam int              CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing samples; any agreeing sample restarts
    // the count, so glitches shorter than DEB_CYC cycles are discarded.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Remember last cycle's debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= stable;
  end

  assign rise_evt = stable & ~prev;
  assign fall_evt = ~stable & prev;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Register-mapped GPIO pad controller: drives the pad cell control pins
// from a small register file and turns debounced pad input edges into a
// sticky write-one-to-clear status with a level interrupt.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NPIN    = 8,
  parameter int DEB_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [3:0]      addr,
  input  logic [NPIN-1:0] wdata,
  output logic [NPIN-1:0] rdata,
  output logic            irq,
  output logic [NPIN-1:0] pad_i,
  output logic [NPIN-1:0] pad_oe,
  output logic [NPIN-1:0] pad_od,
  output logic [NPIN-1:0] pad_ie,
  output logic [NPIN-1:0] pad_pu,
  output logic [NPIN-1:0] pad_pd,
  output logic [NPIN-1:0] pad_ds0,
  output logic [NPIN-1:0] pad_ds1,
  output logic [NPIN-1:0] pad_cs,
  input  logic [NPIN-1:0] pad_c
);

  logic [NPIN-1:0] dout_q, oe_q, od_q, ie_q, pu_q, pd_q, ds0_q, ds1_q, cs_q;
  logic [NPIN-1:0] rise_en_q, fall_en_q, stat_q;
  logic [NPIN-1:0] din, rise_raw, fall_raw, rise_evt, fall_evt;
  logic [NPIN-1:0] stat_clr, rd_mux;

  for (genvar g = 0; g < NPIN; g++) begin : g_pin
    gpio_in_filter #(.DEB_CYC(DEB_CYC)) u_filter (
      .clk      (clk),
      .rst      (rst),
      .pad_c    (pad_c[g]),
      .stable   (din[g]),
      .rise_evt (rise_raw[g]),
      .fall_evt (fall_raw[g])
    );
  end

  // Configuration registers; DIN is read-only and STAT is handled separately.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= {NPIN{RST_DOUT}};
      oe_q      <= {NPIN{RST_OE}};
      od_q      <= {NPIN{RST_OD}};
      ie_q      <= {NPIN{RST_IE}};
      pu_q      <= {NPIN{RST_PU}};
      pd_q      <= {NPIN{RST_PD}};
      ds0_q     <= {NPIN{RST_DS0}};
      ds1_q     <= {NPIN{RST_DS1}};
      cs_q      <= {NPIN{RST_CS}};
      rise_en_q <= {NPIN{RST_RISE_EN}};
      fall_en_q <= {NPIN{RST_FALL_EN}};
    end else if (wr_en) begin
      case (addr)
        ADDR_DOUT:    dout_q    <= wdata;
        ADDR_OE:      oe_q      <= wdata;
        ADDR_OD:      od_q      <= wdata;
        ADDR_IE:      ie_q      <= wdata;
        ADDR_PU:      pu_q      <= wdata;
        ADDR_PD:      pd_q      <= wdata;
        ADDR_DS0:     ds0_q     <= wdata;
        ADDR_DS1:     ds1_q     <= wdata;
        ADDR_CS:      cs_q      <= wdata;
        ADDR_RISE_EN: rise_en_q <= wdata;
        ADDR_FALL_EN: fall_en_q <= wdata;
        default:      ;
      endcase
    end
  end

  assign rise_evt = rise_raw & rise_en_q;
  assign fall_evt = fall_raw & fall_en_q;
  assign stat_clr = (wr_en && (addr == ADDR_STAT)) ? wdata : '0;

  // Sticky event status: write-one-to-clear, with new events winning.
  always_ff @(posedge clk) begin
    if (rst) stat_q <= {NPIN{RST_STAT}};
    else     stat_q <= NPIN'(w1c_update(W1C_W'(stat_q), W1C_W'(stat_clr),
                                        W1C_W'(rise_evt | fall_evt)));
  end

  assign irq = |stat_q;

  // Select the addressed register; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DOUT:    rd_mux = dout_q;
      ADDR_OE:      rd_mux = oe_q;
      ADDR_OD:      rd_mux = od_q;
      ADDR_IE:      rd_mux = ie_q;
      ADDR_PU:      rd_mux = pu_q;
      ADDR_PD:      rd_mux = pd_q;
      ADDR_DS0:     rd_mux = ds0_q;
      ADDR_DS1:     rd_mux = ds1_q;
      ADDR_CS:      rd_mux = cs_q;
      ADDR_DIN:     rd_mux = din;
      ADDR_RISE_EN: rd_mux = rise_en_q;
      ADDR_FALL_EN: rd_mux = fall_en_q;
      ADDR_STAT:    rd_mux = stat_q;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

  // Pull-up and pull-down requested together cancel to no pull.
  assign pad_i   = dout_q;
  assign pad_oe  = oe_q;
  assign pad_od  = od_q;
  assign pad_ie  = ie_q;
  assign pad_pu  = pu_q & ~pd_q;
  assign pad_pd  = pd_q & ~pu_q;
  assign pad_ds0 = ds0_q;
  assign pad_ds1 = ds1_q;
  assign pad_cs  = cs_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed register table, hand
// sequences for debounce/W1C/reset corners, and randomized traffic checked
// every cycle against a behavioural model.
module tb_gpio_pad_ctrl;

  localparam int NPIN    = 8;
  localparam int DEB_CYC = 4;

  logic            clk = 1'b0;
  logic            rst, wr_en, rd_en;
  logic [3:0]      addr;
  logic [NPIN-1:0] wdata, rdata, pad_c;
  logic            irq;
  logic [NPIN-1:0] pad_i, pad_oe, pad_od, pad_ie, pad_pu, pad_pd;
  logic [NPIN-1:0] pad_ds0, pad_ds1, pad_cs;

  gpio_pad_ctrl #(.NPIN(NPIN), .DEB_CYC(DEB_CYC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irq(irq),
    .pad_i(pad_i), .pad_oe(pad_oe), .pad_od(pad_od), .pad_ie(pad_ie),
    .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_ds0(pad_ds0), .pad_ds1(pad_ds1),
    .pad_cs(pad_cs), .pad_c(pad_c)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Behavioural model: register array by address, recent pad samples and
  // the debounced level over the last two cycles.
  logic [NPIN-1:0] m_reg [0:15];
  logic [NPIN-1:0] m_rdata, m_stable, m_stable_old;
  logic [NPIN-1:0] m_samp [$];

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic [7:0] exp_oe;
    logic [7:0] exp_i;
    logic [7:0] exp_pu;
    logic [7:0] exp_pd;
    logic [7:0] exp_ie;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) m_reg[a] = '0;
    m_reg[3]     = '1;
    m_rdata      = '0;
    m_stable     = '0;
    m_stable_old = '0;
    m_samp       = {};
    for (int j = 0; j < DEB_CYC + 2; j++) m_samp.push_back('0);
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [NPIN-1:0] rise, fall, clr, win_and, win_or;
    if (rst) begin
      model_reset();
      return;
    end
    if (rd_en) begin
      if (addr == 4'd9)       m_rdata = m_stable;
      else if (addr <= 4'd12) m_rdata = m_reg[addr];
      else                    m_rdata = '0;
    end
    rise = m_stable & ~m_stable_old & m_reg[10];
    fall = ~m_stable & m_stable_old & m_reg[11];
    clr  = (wr_en && addr == 4'd12) ? wdata : '0;
    if (wr_en && addr <= 4'd11 && addr != 4'd9) m_reg[addr] = wdata;
    m_reg[12] = (m_reg[12] & ~clr) | rise | fall;
    // A pin takes a new level once the sample seen two edges ago and the
    // DEB_CYC-1 before it all agree on that level.
    m_samp.push_back(pad_c);
    win_and = '1;
    win_or  = '0;
    for (int j = 0; j < DEB_CYC; j++) begin
      win_and &= m_samp[m_samp.size() - 3 - j];
      win_or  |= m_samp[m_samp.size() - 3 - j];
    end
    m_stable_old = m_stable;
    m_stable     = (m_stable | win_and) & win_or;
    void'(m_samp.pop_front());
  endtask

  function automatic logic [9*NPIN-1:0] exp_pads();
    return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4] & ~m_reg[5],
            m_reg[5] & ~m_reg[4], m_reg[6], m_reg[7], m_reg[8]};
  endfunction

  // One clock: model follows the edge, DUT is compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput("model_rdata", rdata, m_rdata);
    checkOutput("model_irq", irq, |m_reg[12]);
    checkOutput("model_pads", {pad_i, pad_oe, pad_od, pad_ie, pad_pu, pad_pd,
                               pad_ds0, pad_ds1, pad_cs}, exp_pads());
  endtask

  task automatic drive(input logic r, input logic w, input logic rd,
                       input logic [3:0] a, input logic [7:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    addr  = a;
    wdata = d;
  endtask

  task automatic add_vec(input logic w, input logic rd, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] xr, input logic [7:0] xoe,
                         input logic [7:0] xi, input logic [7:0] xpu,
                         input logic [7:0] xpd, input logic [7:0] xie);
    vec_t v;
    v.wr = w; v.rd = rd; v.addr = a; v.wdata = d; v.exp_rdata = xr;
    v.exp_oe = xoe; v.exp_i = xi; v.exp_pu = xpu; v.exp_pd = xpd; v.exp_ie = xie;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(1'b0, v.wr, v.rd, v.addr, v.wdata);
    step();
    checkOutput("tbl_rdata", rdata, v.exp_rdata);
    checkOutput("tbl_oe", pad_oe, v.exp_oe);
    checkOutput("tbl_i", pad_i, v.exp_i);
    checkOutput("tbl_pu", pad_pu, v.exp_pu);
    checkOutput("tbl_pd", pad_pd, v.exp_pd);
    checkOutput("tbl_ie", pad_ie, v.exp_ie);
    checkOutput("tbl_irq", irq, 1'b0);
  endtask

  initial begin
    pad_c = '0;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    model_reset();
    step();
    step();

    // Reset values on every address, then pad control writes.
    for (int a = 0; a < 13; a++)
      add_vec(1'b0, 1'b1, 4'(a), 8'h00, (a == 3) ? 8'hFF : 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
    add_vec(1'b0, 1'b1, 4'd13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd1,  8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd0,  8'h05, 8'h00, 8'h0F, 8'h05, 8'h00, 8'h00, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd4,  8'h03, 8'h00, 8'h0F, 8'h05, 8'h03, 8'h00, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd5,  8'h06, 8'h00, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b0, 1'b1, 4'd4,  8'h00, 8'h03, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b0, 1'b1, 4'd5,  8'h00, 8'h06, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd9,  8'hAA, 8'h06, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b0, 1'b1, 4'd9,  8'h00, 8'h00, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd14, 8'hFF, 8'h00, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b0, 1'b1, 4'd1,  8'h00, 8'h0F, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b0, 1'b1, 4'd14, 8'h00, 8'h00, 8'h0F, 8'h05, 8'h01, 8'h04, 8'hFF);
    add_vec(1'b1, 1'b0, 4'd3,  8'h00, 8'h00, 8'h0F, 8'h05, 8'h01, 8'h04, 8'h00);
    add_vec(1'b0, 1'b1, 4'd0,  8'h00, 8'h05, 8'h0F, 8'h05, 8'h01, 8'h04, 8'h00);
    add_vec(1'b0, 1'b1, 4'd3,  8'h00, 8'h00, 8'h0F, 8'h05, 8'h01, 8'h04, 8'h00);
    add_vec(1'b1, 1'b0, 4'd4,  8'h00, 8'h00, 8'h0F, 8'h05, 8'h00, 8'h06, 8'h00);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Debounce latency: DIN at edge 6, STAT/irq at edge 7.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    drive(1'b0, 1'b1, 1'b0, 4'd10, 8'h01);
    step();
    drive(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    pad_c = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) begin
        checkOutput("lat_din_e6", rdata, 8'h00);
        checkOutput("lat_irq_e6", irq, 1'b0);
      end
      if (k == 7) begin
        checkOutput("lat_din_e7", rdata, 8'h01);
        checkOutput("lat_irq_e7", irq, 1'b1);
      end
    end

    // Three-cycle glitch on pin 1 is discarded; a held level is accepted.
    drive(1'b0, 1'b1, 1'b0, 4'd10, 8'h03);
    step();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    pad_c = 8'h03;
    repeat (3) step();
    pad_c = 8'h01;
    repeat (8) step();
    drive(1'b0, 1'b0, 1'b1, 4'd12, 8'h00);
    step();
    checkOutput("glitch_stat", rdata, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    step();
    checkOutput("glitch_din", rdata, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    pad_c = 8'h03;
    repeat (8) step();
    drive(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    step();
    checkOutput("held_din", rdata, 8'h03);
    drive(1'b0, 1'b0, 1'b1, 4'd12, 8'h00);
    step();
    checkOutput("held_stat", rdata, 8'h03);

    // W1C colliding with a new fall event on pin 0: the set wins.
    drive(1'b0, 1'b1, 1'b0, 4'd11, 8'h01);
    step();
    drive(1'b0, 1'b1, 1'b0, 4'd12, 8'h03);
    step();
    checkOutput("w1c_clear_all", irq, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    pad_c = 8'h02;
    repeat (6) step();
    drive(1'b0, 1'b1, 1'b0, 4'd12, 8'h01);
    step();
    checkOutput("w1c_collide_irq", irq, 1'b1);
    step();
    checkOutput("w1c_next_irq", irq, 1'b0);

    // Reset in the middle of a debounce with STAT=0x03.
    drive(1'b0, 1'b1, 1'b0, 4'd11, 8'h03);
    step();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    pad_c = 8'h01;
    repeat (8) step();
    pad_c = 8'h00;
    drive(1'b0, 1'b0, 1'b1, 4'd12, 8'h00);
    repeat (4) step();
    checkOutput("pre_rst_stat", rdata, 8'h03);
    checkOutput("pre_rst_irq", irq, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    checkOutput("rst_irq", irq, 1'b0);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_ie", pad_ie, 8'hFF);
    checkOutput("rst_pu", pad_pu, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    pad_c = 8'h02;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) checkOutput("restart_din_e6", rdata, 8'h00);
      if (k == 7) begin
        checkOutput("restart_din_e7", rdata, 8'h02);
        checkOutput("restart_irq", irq, 1'b0);
      end
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 900; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      addr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(9, 12)) : 4'($urandom_range(0, 15));
      wdata = 8'($urandom);
      for (int b = 0; b < NPIN; b++)
        if ($urandom_range(0, 9) == 0) pad_c[b] = ~pad_c[b];
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
